// File: rtl/dds_sweep_ctrl.sv
// ---------------------------------------------------------------------------
// dds_sweep_ctrl
//   Frequency-sweep scheduler for a DDS phase accumulator. Steps the tuning
//   word (fword) from a start word to a stop word by a fixed step, holding
//   each word dwell+1 clocks. Three modes: SINGLE (one pass then done),
//   REPEAT (restart from the start word) and TRIANGLE (ping-pong between the
//   two endpoints). Sweep configuration is captured into shadow registers
//   through a valid/ready handshake that is open only while idle, so a
//   running sweep always sees a stable configuration.
//
// Optional feature macro: SWEEP_PHASE_CLR_EN
//   When defined, adds output phase_clr, a 1-clk pulse coincident with every
//   load of the start word (sweep start and each REPEAT wrap) so the phase
//   accumulator can be zeroed. Not pulsed on TRIANGLE turnarounds or abort.
//
// Ports
//   clk        in   1        system clock
//   rst_n      in   1        synchronous active-low reset
//   cfg_valid  in   1        configuration valid
//   cfg_ready  out  1        configuration accepted when valid&&ready (idle only)
//   cfg_start  in   FW_W     first tuning word
//   cfg_stop   in   FW_W     last tuning word
//   cfg_step   in   FW_W     unsigned step magnitude
//   cfg_dwell  in   DWELL_W  extra hold clocks per word
//   cfg_mode   in   2        0 SINGLE, 1 REPEAT, 2 TRIANGLE, 3 SINGLE
//   start      in   1        begin sweep (ignored unless idle)
//   abort      in   1        stop sweep, highest priority
//   fword      out  FW_W     tuning word (registered)
//   fword_upd  out  1        pulse in the cycle fword takes a new value
//   busy       out  1        sweep running
//   done       out  1        pulse at SINGLE sweep completion
//   phase_clr  out  1        (SWEEP_PHASE_CLR_EN only) start-word load pulse
// ---------------------------------------------------------------------------
module dds_sweep_ctrl #(
  parameter int FW_W    = 32,
  parameter int DWELL_W = 16
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               cfg_valid,
  output logic               cfg_ready,
  input  logic [FW_W-1:0]    cfg_start,
  input  logic [FW_W-1:0]    cfg_stop,
  input  logic [FW_W-1:0]    cfg_step,
  input  logic [DWELL_W-1:0] cfg_dwell,
  input  logic [1:0]         cfg_mode,
  input  logic               start,
  input  logic               abort,
  output logic [FW_W-1:0]    fword,
  output logic               fword_upd,
  output logic               busy,
  output logic               done
`ifdef SWEEP_PHASE_CLR_EN
  ,
  output logic               phase_clr
`endif
);

  typedef enum logic [0:0] {
    IDLE = 1'b0,
    RUN  = 1'b1
  } state_t;

  localparam logic [1:0] MODE_REPEAT   = 2'd1;
  localparam logic [1:0] MODE_TRIANGLE = 2'd2;

  // Move cur one step toward tgt. The sum/difference is formed one bit wider
  // so a carry or borrow out of the word is visible; any overshoot of the
  // target, any wrap, or a zero step lands exactly on the target.
  function automatic logic [FW_W-1:0] step_toward(
    input logic [FW_W-1:0] cur,
    input logic [FW_W-1:0] tgt,
    input logic            up,
    input logic [FW_W-1:0] stp
  );
    logic [FW_W:0]   nxt;
    logic [FW_W-1:0] res;
    if (up) begin
      nxt = {1'b0, cur} + {1'b0, stp};
    end else begin
      nxt = {1'b0, cur} - {1'b0, stp};
    end
    if (stp == {FW_W{1'b0}}) begin
      res = tgt;
    end else if (nxt[FW_W]) begin
      res = tgt;
    end else if (up && (nxt[FW_W-1:0] > tgt)) begin
      res = tgt;
    end else if (!up && (nxt[FW_W-1:0] < tgt)) begin
      res = tgt;
    end else begin
      res = nxt[FW_W-1:0];
    end
    return res;
  endfunction

  state_t             state_r;
  logic [FW_W-1:0]    start_r;
  logic [FW_W-1:0]    stop_r;
  logic [FW_W-1:0]    step_r;
  logic [DWELL_W-1:0] dwell_r;
  logic [1:0]         mode_r;
  // Current sweep leg: from_r is where the leg began, to_r where it ends.
  // TRIANGLE swaps them at every turnaround.
  logic [FW_W-1:0]    from_r;
  logic [FW_W-1:0]    to_r;
  logic               dir_up_r;
  logic [DWELL_W-1:0] dwell_cnt_r;

  logic               cfg_accept_s;
  logic [FW_W-1:0]    eff_start_s;
  logic [FW_W-1:0]    eff_stop_s;
  logic [DWELL_W-1:0] eff_dwell_s;
  logic               at_target_s;
  logic [FW_W-1:0]    fwd_word_s;
  logic [FW_W-1:0]    turn_word_s;

  // Effective config for a start: a handshake in the same cycle as start
  // must take effect immediately, so bypass the shadow registers.
  always_comb begin
    cfg_accept_s = cfg_valid && cfg_ready;
    eff_start_s  = start_r;
    eff_stop_s   = stop_r;
    eff_dwell_s  = dwell_r;
    if (cfg_accept_s) begin
      eff_start_s = cfg_start;
      eff_stop_s  = cfg_stop;
      eff_dwell_s = cfg_dwell;
    end else begin
      eff_start_s = start_r;
      eff_stop_s  = stop_r;
      eff_dwell_s = dwell_r;
    end
  end

  // Candidate next words: continue the current leg, or turn around toward
  // the leg origin (TRIANGLE). step_r is stable while running because the
  // config handshake is closed outside IDLE.
  always_comb begin
    at_target_s = (fword == to_r);
    fwd_word_s  = step_toward(fword, to_r, dir_up_r, step_r);
    turn_word_s = step_toward(fword, from_r, !dir_up_r, step_r);
  end

  // Sweep FSM, shadow config capture and all registered outputs.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_r     <= IDLE;
      start_r     <= {FW_W{1'b0}};
      stop_r      <= {FW_W{1'b0}};
      step_r      <= {FW_W{1'b0}};
      dwell_r     <= {DWELL_W{1'b0}};
      mode_r      <= 2'd0;
      from_r      <= {FW_W{1'b0}};
      to_r        <= {FW_W{1'b0}};
      dir_up_r    <= 1'b1;
      dwell_cnt_r <= {DWELL_W{1'b0}};
      fword       <= {FW_W{1'b0}};
      fword_upd   <= 1'b0;
      busy        <= 1'b0;
      done        <= 1'b0;
      cfg_ready   <= 1'b1;
`ifdef SWEEP_PHASE_CLR_EN
      phase_clr   <= 1'b0;
`endif
    end else begin
      fword_upd <= 1'b0;
      done      <= 1'b0;
`ifdef SWEEP_PHASE_CLR_EN
      phase_clr <= 1'b0;
`endif
      if (cfg_accept_s) begin
        start_r <= cfg_start;
        stop_r  <= cfg_stop;
        step_r  <= cfg_step;
        dwell_r <= cfg_dwell;
        mode_r  <= cfg_mode;
      end

      if (abort) begin
        // fword deliberately holds its current value.
        state_r   <= IDLE;
        busy      <= 1'b0;
        cfg_ready <= 1'b1;
      end else begin
        case (state_r)
          IDLE: begin
            if (start) begin
              state_r     <= RUN;
              fword       <= eff_start_s;
              fword_upd   <= 1'b1;
              busy        <= 1'b1;
              cfg_ready   <= 1'b0;
              dwell_cnt_r <= eff_dwell_s;
              from_r      <= eff_start_s;
              to_r        <= eff_stop_s;
              dir_up_r    <= (eff_stop_s >= eff_start_s);
`ifdef SWEEP_PHASE_CLR_EN
              phase_clr   <= 1'b1;
`endif
            end
          end
          RUN: begin
            if (dwell_cnt_r != {DWELL_W{1'b0}}) begin
              dwell_cnt_r <= dwell_cnt_r - DWELL_W'(1);
            end else if (!at_target_s) begin
              fword       <= fwd_word_s;
              fword_upd   <= 1'b1;
              dwell_cnt_r <= dwell_r;
            end else begin
              case (mode_r)
                MODE_REPEAT: begin
                  fword       <= from_r;
                  fword_upd   <= 1'b1;
                  dwell_cnt_r <= dwell_r;
`ifdef SWEEP_PHASE_CLR_EN
                  phase_clr   <= 1'b1;
`endif
                end
                MODE_TRIANGLE: begin
                  // Turnaround: the first word of the new leg is already one
                  // step back toward the old origin.
                  fword       <= turn_word_s;
                  fword_upd   <= 1'b1;
                  dwell_cnt_r <= dwell_r;
                  from_r      <= to_r;
                  to_r        <= from_r;
                  dir_up_r    <= !dir_up_r;
                end
                default: begin
                  // SINGLE (mode 0 and 3): finished, stop word stays.
                  state_r   <= IDLE;
                  busy      <= 1'b0;
                  done      <= 1'b1;
                  cfg_ready <= 1'b1;
                end
              endcase
            end
          end
          default: begin
            state_r   <= IDLE;
            busy      <= 1'b0;
            cfg_ready <= 1'b1;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_dds_sweep_ctrl.sv
// ---------------------------------------------------------------------------
// tb_dds_sweep_ctrl
//   Scoreboard bench: stimulus pushes expected events (word updates and done
//   pulses, with the cycle gap since the previous event) into a queue; a
//   monitor pops and compares whenever the DUT pulses fword_upd or done.
// ---------------------------------------------------------------------------
module tb_dds_sweep_ctrl;

  localparam int FW_W    = 32;
  localparam int DWELL_W = 16;

  logic               clk;
  logic               rst_n;
  logic               cfg_valid;
  logic               cfg_ready;
  logic [FW_W-1:0]    cfg_start;
  logic [FW_W-1:0]    cfg_stop;
  logic [FW_W-1:0]    cfg_step;
  logic [DWELL_W-1:0] cfg_dwell;
  logic [1:0]         cfg_mode;
  logic               start;
  logic               abort;
  logic [FW_W-1:0]    fword;
  logic               fword_upd;
  logic               busy;
  logic               done;
`ifdef SWEEP_PHASE_CLR_EN
  logic               phase_clr;
`endif

  dds_sweep_ctrl #(.FW_W(FW_W), .DWELL_W(DWELL_W)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .cfg_valid (cfg_valid),
    .cfg_ready (cfg_ready),
    .cfg_start (cfg_start),
    .cfg_stop  (cfg_stop),
    .cfg_step  (cfg_step),
    .cfg_dwell (cfg_dwell),
    .cfg_mode  (cfg_mode),
    .start     (start),
    .abort     (abort),
    .fword     (fword),
    .fword_upd (fword_upd),
    .busy      (busy),
    .done      (done)
`ifdef SWEEP_PHASE_CLR_EN
    ,
    .phase_clr (phase_clr)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    int          kind;   // 0 word update, 1 done
    logic [31:0] value;  // fword at the event
    int          gap;    // cycles since previous event, -1 = don't care
    logic        pclr;   // expected phase_clr with a word update
  } evt_t;

  evt_t exp_q[$];
  int   n_pass  = 0;
  int   n_total = 0;
  int   cyc     = 0;
  int   last_cyc = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  task automatic push(input int kind, input logic [31:0] value, input int gap, input logic pclr);
    evt_t e;
    e.kind = kind; e.value = value; e.gap = gap; e.pclr = pclr;
    exp_q.push_back(e);
  endtask

  // Monitor: compare every DUT event against the head of the scoreboard.
  initial begin
    evt_t e;
    int   gap;
    forever begin
      @(negedge clk);
      if (fword_upd || done) begin
        gap      = cyc - last_cyc;
        last_cyc = cyc;
        if (exp_q.size() == 0) begin
          chk("unexpected_event", {31'd0, done, 32'(fword)}, 64'hFFFF_FFFF_FFFF_FFFF);
        end else begin
          e = exp_q.pop_front();
          chk("event_kind", 64'(done ? 1 : 0), 64'(e.kind));
          chk("event_fword", 64'(fword), 64'(e.value));
          if (e.gap >= 0) chk("event_gap", 64'(gap), 64'(e.gap));
`ifdef SWEEP_PHASE_CLR_EN
          if (e.kind == 0) chk("phase_clr", 64'(phase_clr), 64'(e.pclr));
`endif
        end
      end
    end
  end

  task automatic step_clk();
    @(negedge clk);
    #1;
  endtask

  task automatic cfg_load(input logic [31:0] s, input logic [31:0] p, input logic [31:0] st,
                          input logic [15:0] dw, input logic [1:0] md, input logic with_start);
    chk("cfg_ready_idle", 64'(cfg_ready), 64'd1);
    cfg_valid = 1'b1; cfg_start = s; cfg_stop = p; cfg_step = st; cfg_dwell = dw; cfg_mode = md;
    start = with_start;
    step_clk();
    cfg_valid = 1'b0; start = 1'b0;
  endtask

  task automatic pulse_start();
    start = 1'b1;
    step_clk();
    start = 1'b0;
  endtask

  task automatic pulse_abort();
    abort = 1'b1;
    step_clk();
    abort = 1'b0;
  endtask

  task automatic wait_drain(input string name, input int budget);
    int n;
    n = 0;
    while (exp_q.size() != 0 && n < budget) begin
      step_clk();
      n++;
    end
    if (exp_q.size() != 0) begin
      chk(name, 64'(exp_q.size()), 64'd0);
      exp_q.delete();
    end
  endtask

  initial begin
    rst_n = 1'b0; cfg_valid = 1'b0; cfg_start = '0; cfg_stop = '0; cfg_step = '0;
    cfg_dwell = '0; cfg_mode = 2'd0; start = 1'b0; abort = 1'b0;
    repeat (3) step_clk();
    chk("rst_fword", 64'(fword), 64'd0);
    chk("rst_upd", 64'(fword_upd), 64'd0);
    chk("rst_busy", 64'(busy), 64'd0);
    chk("rst_done", 64'(done), 64'd0);
    chk("rst_cfg_ready", 64'(cfg_ready), 64'd1);
    rst_n = 1'b1;
    step_clk();

    // 1: SINGLE 1000..1300 step 100 dwell 2
    cfg_load(32'd1000, 32'd1300, 32'd100, 16'd2, 2'd0, 1'b0);
    push(0, 32'd1000, -1, 1'b1);
    push(0, 32'd1100, 3, 1'b0);
    push(0, 32'd1200, 3, 1'b0);
    push(0, 32'd1300, 3, 1'b0);
    push(1, 32'd1300, 3, 1'b0);
    pulse_start();
    chk("t1_busy_run", 64'(busy), 64'd1);
    chk("t1_cfg_ready_run", 64'(cfg_ready), 64'd0);
    wait_drain("t1_drain", 40);
    chk("t1_busy_after", 64'(busy), 64'd0);
    chk("t1_fword_after", 64'(fword), 64'd1300);
    chk("t1_cfg_ready_after", 64'(cfg_ready), 64'd1);

    // 2: clamp at stop
    cfg_load(32'd1000, 32'd1250, 32'd100, 16'd0, 2'd3, 1'b0);
    push(0, 32'd1000, -1, 1'b1);
    push(0, 32'd1100, 1, 1'b0);
    push(0, 32'd1200, 1, 1'b0);
    push(0, 32'd1250, 1, 1'b0);
    push(1, 32'd1250, 1, 1'b0);
    pulse_start();
    wait_drain("t2_drain", 20);
    chk("t2_busy_after", 64'(busy), 64'd0);

    // 3: TRIANGLE 500 -> 200 and back
    cfg_load(32'd500, 32'd200, 32'd100, 16'd1, 2'd2, 1'b0);
    push(0, 32'd500, -1, 1'b1);
    push(0, 32'd400, 2, 1'b0);
    push(0, 32'd300, 2, 1'b0);
    push(0, 32'd200, 2, 1'b0);
    push(0, 32'd300, 2, 1'b0);
    push(0, 32'd400, 2, 1'b0);
    push(0, 32'd500, 2, 1'b0);
    push(0, 32'd400, 2, 1'b0);
    push(0, 32'd300, 2, 1'b0);
    pulse_start();
    wait_drain("t3_drain", 40);
    chk("t3_busy_still", 64'(busy), 64'd1);
    pulse_abort();
    chk("t3_busy_abort", 64'(busy), 64'd0);

    // 4: REPEAT near top of range, no wrap to 0
    cfg_load(32'hFFFF_FF00, 32'hFFFF_FFFF, 32'h80, 16'd0, 2'd1, 1'b0);
    push(0, 32'hFFFF_FF00, -1, 1'b1);
    push(0, 32'hFFFF_FF80, 1, 1'b0);
    push(0, 32'hFFFF_FFFF, 1, 1'b0);
    push(0, 32'hFFFF_FF00, 1, 1'b1);
    push(0, 32'hFFFF_FF80, 1, 1'b0);
    pulse_start();
    wait_drain("t4_drain", 20);
    pulse_abort();

    // 5: abort during 1100 of sweep 1, then abort+start in IDLE
    cfg_load(32'd1000, 32'd1300, 32'd100, 16'd2, 2'd0, 1'b0);
    push(0, 32'd1000, -1, 1'b1);
    push(0, 32'd1100, 3, 1'b0);
    pulse_start();
    wait_drain("t5_drain", 20);
    pulse_abort();
    chk("t5_busy", 64'(busy), 64'd0);
    chk("t5_fword", 64'(fword), 64'd1100);
    chk("t5_done", 64'(done), 64'd0);
    chk("t5_cfg_ready", 64'(cfg_ready), 64'd1);
    repeat (5) step_clk();
    start = 1'b1; abort = 1'b1;
    step_clk();
    start = 1'b0; abort = 1'b0;
    chk("t5_abort_start_busy", 64'(busy), 64'd0);
    repeat (3) step_clk();
    chk("t5_abort_start_fword", 64'(fword), 64'd1100);

    // 6a: handshake and start in the same cycle use the new config
    push(0, 32'd2000, -1, 1'b1);
    push(0, 32'd2050, 1, 1'b0);
    push(0, 32'd2100, 1, 1'b0);
    push(0, 32'd2120, 1, 1'b0);
    push(1, 32'd2120, 1, 1'b0);
    cfg_load(32'd2000, 32'd2120, 32'd50, 16'd0, 2'd0, 1'b1);
    wait_drain("t6a_drain", 20);

    // 6b: config offered while busy is refused, shadow unchanged
    push(0, 32'd2000, -1, 1'b1);
    push(0, 32'd2050, 1, 1'b0);
    push(0, 32'd2100, 1, 1'b0);
    push(0, 32'd2120, 1, 1'b0);
    push(1, 32'd2120, 1, 1'b0);
    pulse_start();
    cfg_valid = 1'b1; cfg_start = 32'd7; cfg_stop = 32'd9; cfg_step = 32'd1;
    cfg_dwell = 16'd5; cfg_mode = 2'd1;
    chk("t6b_cfg_ready_busy", 64'(cfg_ready), 64'd0);
    step_clk();
    cfg_valid = 1'b0;
    wait_drain("t6b_drain", 20);

    // 6c: reset mid-sweep, then start from zeroed shadow (start==stop==0)
    push(0, 32'd2000, -1, 1'b1);
    pulse_start();
    wait_drain("t6c_drain", 10);
    rst_n = 1'b0;
    step_clk();
    chk("t6c_rst_fword", 64'(fword), 64'd0);
    chk("t6c_rst_busy", 64'(busy), 64'd0);
    chk("t6c_rst_cfg_ready", 64'(cfg_ready), 64'd1);
    rst_n = 1'b1;
    step_clk();
    push(0, 32'd0, -1, 1'b1);
    push(1, 32'd0, 1, 1'b0);
    pulse_start();
    wait_drain("t6c_zero_drain", 10);
    repeat (4) step_clk();
    chk("final_queue_empty", 64'(exp_q.size()), 64'd0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
